spectrum_peak_classify: RTL and testbench

Parametrised spectrum analyser back-end. It scans an FFT-magnitude RAM over a configurable bin window and extracts the NUM_PEAKS strongest local-maximum tones. For each tone it reads the configurable HARM-th harmonic and classifies the waveform as sine or non-sine. It replaces the fixed two-tone, 3rd-harmonic detector, sits after the FFT magnitude RAM write stage, and feeds the display/DDS control logic.

---
 rtl/spectrum_peak_classify.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_spectrum_peak_classify.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_classify.sv
// spectrum_peak_classify
//   Scans an FFT-magnitude RAM over [ADDR_LO, ADDR_HI]. It keeps the NUM_PEAKS
//   strongest local maxima, sorted by magnitude in descending order. For each
//   tone it then checks the HARM-th harmonic against its neighbour bins and
//   classifies the waveform as sine or non-sine.
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   en                  RAM-valid level; a rising edge starts a measurement
//   key                 active-low restart button; a press aborts or rearms
//   rd_addr / rd_data   RAM read port; data is valid one cycle after the address
//   peak_bin/freq/mag   per-slot results, slot i at [i*W +: W]
//   peak_found/sin/ovl  per-slot flags
//   busy                high while scanning or measuring harmonics
//   valid               high while results are complete and held
module spectrum_peak_classify #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 12,
  parameter int NUM_PEAKS  = 2,
  parameter int ADDR_LO    = 128,
  parameter int ADDR_HI    = 640,
  parameter int HARM       = 3,
  parameter int GUARD      = 2,
  parameter int SIN_THRESH = 16,
  parameter int MIN_MAG    = 32,
  parameter int FREQ_SHIFT = 5
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    en,
  input  logic                                    key,
  input  logic [DATA_W-1:0]                       rd_data,
  output logic [ADDR_W-1:0]                       rd_addr,
  output logic [NUM_PEAKS*ADDR_W-1:0]             peak_bin,
  output logic [NUM_PEAKS*(ADDR_W-FREQ_SHIFT)-1:0] peak_freq,
  output logic [NUM_PEAKS*DATA_W-1:0]             peak_mag,
  output logic [NUM_PEAKS-1:0]                    peak_found,
  output logic [NUM_PEAKS-1:0]                    peak_sin,
  output logic [NUM_PEAKS-1:0]                    peak_ovl,
  output logic                                    busy,
  output logic                                    valid
);

  localparam int HW = ADDR_W + 3;
  localparam int KW = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;
  localparam int FW = ADDR_W - FREQ_SHIFT;
  localparam int SW = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_HARM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_START = ADDR_W'(ADDR_LO - 1);
  localparam logic [ADDR_W-1:0] ADDR_END   = ADDR_W'(ADDR_HI + 1);
  localparam logic [ADDR_W-1:0] BIN_LO     = ADDR_W'(ADDR_LO);
  localparam logic [ADDR_W-1:0] BIN_HI     = ADDR_W'(ADDR_HI);
  localparam logic [ADDR_W-1:0] GUARD_A    = ADDR_W'(GUARD);
  localparam logic [HW-1:0]     HARM_C     = HW'(HARM);
  localparam logic [HW-1:0]     GUARD_H    = HW'(GUARD);
  localparam logic [HW-1:0]     H_MAX      = HW'((1 << ADDR_W) - 1);
  localparam logic [DATA_W-1:0] MIN_MAG_C  = DATA_W'(MIN_MAG);
  localparam logic [DATA_W-1:0] THRESH_C   = DATA_W'(SIN_THRESH);
  localparam logic [KW-1:0]     K_LAST     = KW'(NUM_PEAKS - 1);
  // Harmonic slot step numbering:
  //   step 0          decide skip, or load the first read address
  //   steps 2..2G+2   data of offset d = step-2 arrives
  //   step 2G+2       last neighbour arrives and sin is decided
  localparam logic [SW-1:0] ST_RD_LAST = SW'(2 * GUARD);
  localparam logic [SW-1:0] ST_CENTER  = SW'(GUARD + 2);
  localparam logic [SW-1:0] ST_LAST    = SW'(2 * GUARD + 2);

  logic [2:0]        state_r;
  logic              en_d0_r, en_d1_r, key_d0_r, key_d1_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [DATA_W-1:0] w0_r, w1_r;            // cur and prev window samples
  logic [ADDR_W-1:0] bin_r [NUM_PEAKS];
  logic [DATA_W-1:0] mag_r [NUM_PEAKS];
  logic [NUM_PEAKS-1:0] found_r, sin_r, ovl_r;
  logic [KW-1:0]     k_r;
  logic [SW-1:0]     st_r;
  logic [DATA_W-1:0] hmag_r, nmax_r;
  logic              busy_r, valid_r;

  logic              en_rise_s, key_fall_s;
  logic [ADDR_W-1:0] cand_bin_s;
  logic              cand_ok_s;
  logic [NUM_PEAKS-1:0] gt_s, ins_found_s;
  logic [ADDR_W-1:0] ins_bin_s [NUM_PEAKS];
  logic [DATA_W-1:0] ins_mag_s [NUM_PEAKS];
  logic [ADDR_W-1:0] bin_k_s;
  logic [HW-1:0]     h_s;
  logic              oor_s, ovl_hit_s, nxt_found_s, last_slot_s;
  logic [DATA_W-1:0] n_fin_s;
  logic              sin_fin_s, slot_done_s, slot_sin_s, slot_ovl_s;

  assign en_rise_s  = en_d0_r & ~en_d1_r;
  assign key_fall_s = ~key_d0_r & key_d1_r;

  // Candidate test: w0 is bin b, w1 is b-1 and the live read data is b+1
  always_comb begin
    cand_bin_s = (state_r == S_DRAIN) ? BIN_HI : (rd_addr_r - ADDR_W'(2));
    cand_ok_s  = ((state_r == S_SCAN) | (state_r == S_DRAIN)) &
                 (cand_bin_s >= BIN_LO) & (cand_bin_s <= BIN_HI) &
                 (w0_r >= w1_r) & (w0_r > rd_data) & (w0_r >= MIN_MAG_C);
  end

  // Sorted insertion. gt_s is monotone over the sorted list, so its first set
  // bit takes the candidate and every later set bit takes its upper neighbour.
  always_comb begin
    logic              up_gt_s;
    logic [ADDR_W-1:0] up_bin_s;
    logic [DATA_W-1:0] up_mag_s;
    logic              up_found_s;
    up_gt_s     = 1'b0;
    up_bin_s    = '0;
    up_mag_s    = '0;
    up_found_s  = 1'b0;
    gt_s        = '0;
    ins_found_s = found_r;
    for (int i = 0; i < NUM_PEAKS; i++) begin
      gt_s[i] = cand_ok_s & (~found_r[i] | (w0_r > mag_r[i]));
      if (gt_s[i] & ~up_gt_s) begin
        ins_bin_s[i]   = cand_bin_s;
        ins_mag_s[i]   = w0_r;
        ins_found_s[i] = 1'b1;
      end else if (gt_s[i]) begin
        ins_bin_s[i]   = up_bin_s;
        ins_mag_s[i]   = up_mag_s;
        ins_found_s[i] = up_found_s;
      end else begin
        ins_bin_s[i]   = bin_r[i];
        ins_mag_s[i]   = mag_r[i];
        ins_found_s[i] = found_r[i];
      end
      up_gt_s    = gt_s[i];
      up_bin_s   = bin_r[i];
      up_mag_s   = mag_r[i];
      up_found_s = found_r[i];
    end
  end

  // Harmonic position of slot k, range/overlap checks and final sine decision
  always_comb begin
    bin_k_s     = bin_r[k_r];
    h_s         = HARM_C * {3'b000, bin_k_s};
    oor_s       = (h_s + GUARD_H) > H_MAX;
    ovl_hit_s   = 1'b0;
    nxt_found_s = 1'b0;
    for (int j = 0; j < NUM_PEAKS; j++) begin
      ovl_hit_s = ovl_hit_s | ((KW'(j) != k_r) & found_r[j] &
                               (h_s <= ({3'b000, bin_r[j]} + GUARD_H)) &
                               ({3'b000, bin_r[j]} <= (h_s + GUARD_H)));
      nxt_found_s = nxt_found_s | (((int'(k_r) + 1) == j) & found_r[j]);
    end
    // Found slots are contiguous from slot 0, so the first unfound one ends HARM
    last_slot_s = (k_r == K_LAST) | ~nxt_found_s;
    n_fin_s     = (rd_data > nmax_r) ? rd_data : nmax_r;
    sin_fin_s   = ~((hmag_r > n_fin_s) & ((hmag_r - n_fin_s) >= THRESH_C));
    slot_done_s = ((st_r == SW'(0)) & (oor_s | ovl_hit_s)) | (st_r == ST_LAST);
    slot_sin_s  = (st_r == SW'(0)) ? 1'b1 : sin_fin_s;
    slot_ovl_s  = (st_r == SW'(0)) & ~oor_s & ovl_hit_s;
  end

  // Synchronisers, control FSM, scan window, top-N list and harmonic measurement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      en_d0_r   <= 1'b0;
      en_d1_r   <= 1'b0;
      key_d0_r  <= 1'b1;
      key_d1_r  <= 1'b1;
      rd_addr_r <= ADDR_START;
      w0_r      <= '0;
      w1_r      <= '0;
      for (int i = 0; i < NUM_PEAKS; i++) begin
        bin_r[i] <= '0;
        mag_r[i] <= '0;
      end
      found_r   <= '0;
      sin_r     <= '0;
      ovl_r     <= '0;
      k_r       <= '0;
      st_r      <= '0;
      hmag_r    <= '0;
      nmax_r    <= '0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      en_d0_r  <= en;
      en_d1_r  <= en_d0_r;
      key_d0_r <= key;
      key_d1_r <= key_d0_r;
      busy_r   <= (state_r == S_SCAN) | (state_r == S_DRAIN) | (state_r == S_HARM);
      valid_r  <= (state_r == S_DONE);
      case (state_r)
        S_IDLE: begin
          rd_addr_r <= ADDR_START;
          for (int i = 0; i < NUM_PEAKS; i++) begin
            bin_r[i] <= '0;
            mag_r[i] <= '0;
          end
          found_r <= '0;
          sin_r   <= '0;
          ovl_r   <= '0;
          k_r     <= '0;
          st_r    <= '0;
          if (en_rise_s & ~key_fall_s) begin
            state_r <= S_SCAN;
          end
        end
        S_SCAN, S_DRAIN: begin
          if (key_fall_s) begin
            state_r <= S_IDLE;
          end else begin
            w1_r <= w0_r;
            w0_r <= rd_data;
            for (int i = 0; i < NUM_PEAKS; i++) begin
              bin_r[i] <= ins_bin_s[i];
              mag_r[i] <= ins_mag_s[i];
            end
            found_r <= ins_found_s;
            if (state_r == S_DRAIN) begin
              k_r     <= '0;
              st_r    <= '0;
              state_r <= ins_found_s[0] ? S_HARM : S_DONE;
            end else if (rd_addr_r == ADDR_END) begin
              state_r <= S_DRAIN;
            end else begin
              rd_addr_r <= rd_addr_r + ADDR_W'(1);
            end
          end
        end
        S_HARM: begin
          if (key_fall_s) begin
            state_r <= S_IDLE;
          end else if (slot_done_s) begin
            st_r       <= '0;
            sin_r[k_r] <= slot_sin_s;
            ovl_r[k_r] <= slot_ovl_s;
            if (last_slot_s) begin
              state_r <= S_DONE;
            end else begin
              k_r <= k_r + KW'(1);
            end
          end else begin
            st_r <= st_r + SW'(1);
            if (st_r == SW'(0)) begin
              rd_addr_r <= h_s[ADDR_W-1:0] - GUARD_A;
              hmag_r    <= '0;
              nmax_r    <= '0;
            end else begin
              if (st_r <= ST_RD_LAST) begin
                rd_addr_r <= rd_addr_r + ADDR_W'(1);
              end
              if (st_r == ST_CENTER) begin
                hmag_r <= rd_data;
              end else if (st_r >= SW'(2)) begin
                nmax_r <= n_fin_s;
              end
            end
          end
        end
        S_DONE: begin
          if (key_fall_s) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Flatten per-slot result registers onto the output buses
  always_comb begin
    peak_bin  = '0;
    peak_freq = '0;
    peak_mag  = '0;
    for (int i = 0; i < NUM_PEAKS; i++) begin
      peak_bin[i*ADDR_W +: ADDR_W] = bin_r[i];
      peak_freq[i*FW +: FW]        = bin_r[i][ADDR_W-1:FREQ_SHIFT];
      peak_mag[i*DATA_W +: DATA_W] = mag_r[i];
    end
  end

  assign rd_addr    = rd_addr_r;
  assign peak_found = found_r;
  assign peak_sin   = sin_r;
  assign peak_ovl   = ovl_r;
  assign busy       = busy_r;
  assign valid      = valid_r;

endmodule

// File: tb/tb_spectrum_peak_classify.sv
// Directed bench for spectrum_peak_classify.
// dut_a uses the default window. dut_b widens the window to bin 1500, so that
// a tone whose harmonic falls outside the RAM can be placed in the scan range.
module tb_spectrum_peak_classify;

  logic        clk;
  logic        rst_n;
  logic        en_a, en_b, key;
  logic [15:0] rd_data_a, rd_data_b;
  logic [11:0] rd_addr_a, rd_addr_b;
  logic [23:0] peak_bin_a, peak_bin_b;
  logic [13:0] peak_freq_a, peak_freq_b;
  logic [31:0] peak_mag_a, peak_mag_b;
  logic [1:0]  found_a, found_b, sin_a, sin_b, ovl_a, ovl_b;
  logic        busy_a, busy_b, valid_a, valid_b;

  logic [15:0] mem_a [4096];
  logic [15:0] mem_b [4096];

  int checks   = 0;
  int failures = 0;
  int lat, dur;

  spectrum_peak_classify dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .key(key), .rd_data(rd_data_a),
    .rd_addr(rd_addr_a), .peak_bin(peak_bin_a), .peak_freq(peak_freq_a),
    .peak_mag(peak_mag_a), .peak_found(found_a), .peak_sin(sin_a),
    .peak_ovl(ovl_a), .busy(busy_a), .valid(valid_a)
  );

  spectrum_peak_classify #(.ADDR_HI(1500)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .key(key), .rd_data(rd_data_b),
    .rd_addr(rd_addr_b), .peak_bin(peak_bin_b), .peak_freq(peak_freq_b),
    .peak_mag(peak_mag_b), .peak_found(found_b), .peak_sin(sin_b),
    .peak_ovl(ovl_b), .busy(busy_b), .valid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM models
  always @(posedge clk) begin
    rd_data_a <= mem_a[rd_addr_a];
    rd_data_b <= mem_b[rd_addr_b];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_floor();
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = 16'd10;
      mem_b[i] = 16'd10;
    end
  endtask

  // Raise en on one DUT and count edges until busy is seen (bounded)
  task automatic start_en(input bit sel, output int n);
    en_a = 1'b0;
    en_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (sel) en_b = 1'b1;
    else en_a = 1'b1;
    n = 0;
    while (n < 10 && !(sel ? busy_b : busy_a)) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Count edges from busy until valid is seen (bounded)
  task automatic wait_valid(input bit sel, output int n);
    n = 0;
    while (n < 3000 && !(sel ? valid_b : valid_a)) begin
      @(posedge clk);
      #1;
      n++;
    end
    en_a = 1'b0;
    en_b = 1'b0;
  endtask

  task automatic press_key();
    @(posedge clk);
    #1;
    key = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    key = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    key   = 1'b1;
    fill_floor();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd_addr", rd_addr_a, 64'd127);
    check_eq("rst_busy", busy_a, 64'd0);
    check_eq("rst_valid", valid_a, 64'd0);
    check_eq("rst_results", {peak_bin_a, peak_mag_a, found_a, sin_a, ovl_a}, 64'd0);
    rst_n = 1'b1;

    // Two clean sines
    mem_a[160] = 16'd1000;
    mem_a[400] = 16'd800;
    start_en(1'b0, lat);
    check_eq("t1_start_latency", lat, 64'd3);
    wait_valid(1'b0, dur);
    check_eq("t1_valid_cycles", dur, 64'd530);
    check_eq("t1_bin", peak_bin_a, {12'd400, 12'd160});
    check_eq("t1_freq", peak_freq_a, {7'd12, 7'd5});
    check_eq("t1_mag", peak_mag_a, {16'd800, 16'd1000});
    check_eq("t1_flags", {found_a, sin_a, ovl_a}, {2'b11, 2'b11, 2'b00});
    check_eq("t1_busy_done", busy_a, 64'd0);
    press_key();
    check_eq("t1_rearm_valid", valid_a, 64'd0);
    check_eq("t1_rearm_cleared", {peak_bin_a, found_a}, 64'd0);

    // Strong 3rd harmonic on the 200 tone; the 600 bin is only a third candidate
    fill_floor();
    mem_a[200] = 16'd900;
    mem_a[600] = 16'd100;
    mem_a[300] = 16'd700;
    start_en(1'b0, lat);
    wait_valid(1'b0, dur);
    check_eq("t2_valid_cycles", dur, 64'd530);
    check_eq("t2_bin", peak_bin_a, {12'd300, 12'd200});
    check_eq("t2_freq", peak_freq_a, {7'd9, 7'd6});
    check_eq("t2_mag", peak_mag_a, {16'd700, 16'd900});
    check_eq("t2_flags", {found_a, sin_a, ovl_a}, {2'b11, 2'b10, 2'b00});
    press_key();

    // Harmonic of slot 0 lands on slot 1
    fill_floor();
    mem_a[150] = 16'd900;
    mem_a[450] = 16'd500;
    start_en(1'b0, lat);
    wait_valid(1'b0, dur);
    check_eq("t3_valid_cycles", dur, 64'd524);
    check_eq("t3_bin", peak_bin_a, {12'd450, 12'd150});
    check_eq("t3_flags", {found_a, sin_a, ovl_a}, {2'b11, 2'b11, 2'b01});
    press_key();

    // Leakage skirt around a single tone
    fill_floor();
    mem_a[199] = 16'd300;
    mem_a[200] = 16'd900;
    mem_a[201] = 16'd400;
    start_en(1'b0, lat);
    wait_valid(1'b0, dur);
    check_eq("t4_valid_cycles", dur, 64'd523);
    check_eq("t4_bin", peak_bin_a, {12'd0, 12'd200});
    check_eq("t4_freq", peak_freq_a, {7'd0, 7'd6});
    check_eq("t4_mag", peak_mag_a, {16'd0, 16'd900});
    check_eq("t4_flags", {found_a, sin_a, ovl_a}, {2'b01, 2'b01, 2'b00});
    press_key();

    // Equal magnitudes: the lower bin ranks first
    fill_floor();
    mem_a[180] = 16'd600;
    mem_a[500] = 16'd600;
    start_en(1'b0, lat);
    wait_valid(1'b0, dur);
    check_eq("t5_bin", peak_bin_a, {12'd500, 12'd180});
    check_eq("t5_mag", peak_mag_a, {16'd600, 16'd600});
    check_eq("t5_flags", {found_a, sin_a, ovl_a}, {2'b11, 2'b11, 2'b00});
    press_key();

    // Wide window: the 1400 tone has its harmonic at 4200, beyond the RAM
    mem_b[180]  = 16'd600;
    mem_b[1400] = 16'd600;
    start_en(1'b1, lat);
    check_eq("t5b_start_latency", lat, 64'd3);
    wait_valid(1'b1, dur);
    check_eq("t5b_valid_cycles", dur, 64'd1384);
    check_eq("t5b_bin", peak_bin_b, {12'd1400, 12'd180});
    check_eq("t5b_freq", peak_freq_b, {7'd43, 7'd5});
    check_eq("t5b_flags", {found_b, sin_b, ovl_b}, {2'b11, 2'b11, 2'b00});
    press_key();

    // Key press partway through SCAN aborts
    fill_floor();
    mem_a[160] = 16'd1000;
    mem_a[400] = 16'd800;
    start_en(1'b0, lat);
    repeat (100) @(posedge clk);
    #1;
    key = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_abort_busy", busy_a, 64'd0);
    check_eq("t6_abort_rd_addr", rd_addr_a, 64'd127);
    check_eq("t6_abort_valid", valid_a, 64'd0);
    key  = 1'b1;
    en_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset pulse during HARM clears everything before the next edge
    start_en(1'b0, lat);
    repeat (520) @(posedge clk);
    #1;
    check_eq("t6_in_harm_found", found_a, 64'd3);
    rst_n = 1'b0;
    en_a  = 1'b0;
    #2;
    check_eq("t6_async_rst_results", {peak_bin_a, peak_mag_a, found_a, sin_a, ovl_a}, 64'd0);
    check_eq("t6_async_rst_ctrl", {busy_a, valid_a, rd_addr_a}, {1'b0, 1'b0, 12'd127});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_en(1'b0, lat);
    check_eq("t6_restart_latency", lat, 64'd3);
    wait_valid(1'b0, dur);
    check_eq("t6_restart_cycles", dur, 64'd530);
    check_eq("t6_restart_bin", peak_bin_a, {12'd400, 12'd160});
    check_eq("t6_restart_flags", {found_a, sin_a, ovl_a}, {2'b11, 2'b11, 2'b00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
